// File: rtl/dump_pkg.sv
// Shared definitions for the pipeline dump engine: FSM encoding, frame
// delimiters and a byte-extraction helper.
package dump_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HEADER    = 4'd1,
    ST_PC        = 4'd2,
    ST_REG_REQ   = 4'd3,
    ST_REG_LATCH = 4'd4,
    ST_REG_SEND  = 4'd5,
    ST_MEM_REQ   = 4'd6,
    ST_MEM_LATCH = 4'd7,
    ST_MEM_SEND  = 4'd8,
    ST_TRAILER   = 4'd9
  } dump_state_e;

  localparam logic [7:0] DUMP_HDR       = 8'hA5;
  localparam logic [7:0] DUMP_TRL       = 8'h5A;
  localparam int         N_REGS         = 32;
  localparam int         BYTES_PER_WORD = 4;

  function automatic logic [7:0] msb_byte(input logic [31:0] word);
    return word[31:24];
  endfunction

endpackage

// File: rtl/pipeline_dump_unit_if.sv
// Byte stream from the dump engine toward the UART transmitter.
interface pipeline_dump_unit_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dump_word_serializer.sv
// Holds one 32-bit word and walks it out MSB-first, one byte per accepted
// transfer, flagging the final byte of the word.
module dump_word_serializer #(
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_advance,
  output logic [7:0]         o_byte,
  output logic [7:0]         o_next_byte,
  output logic               o_last
);
  import dump_pkg::*;

  localparam int NB_CNT = $clog2(BYTES_PER_WORD);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;

  // next word/byte position: a load restarts the word, an advance drops the sent byte
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      shift_d = i_word;
      cnt_d   = {NB_CNT{1'b0}};
    end else if (i_advance) begin
      shift_d = {shift_q[NB_DATA-9:0], 8'h00};
      cnt_d   = cnt_q + NB_CNT'(1);
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // shift register and byte counter
  always_ff @(posedge clk) begin
    if (i_rst) begin
      shift_q <= {NB_DATA{1'b0}};
      cnt_q   <= {NB_CNT{1'b0}};
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_byte      = shift_q[NB_DATA-1 -: 8];
  assign o_next_byte = shift_q[NB_DATA-9 -: 8];
  assign o_last      = (cnt_q == NB_CNT'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/pipeline_dump_unit.sv
// Debug readout engine: snapshots the PC, walks the register file and data
// memory through their read ports and streams a framed byte dump.
module pipeline_dump_unit #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_MEM_ADDR = 8,
  parameter int N_MEM_WORDS = 64
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [NB_DATA-1:0]     i_pc,
  output logic [NB_ADDR-1:0]     o_reg_addr,
  input  logic [NB_DATA-1:0]     i_reg_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0]     i_mem_data,
  pipeline_dump_unit_if.master   tx,
  output logic                   o_busy,
  output logic                   o_done
);
  import dump_pkg::*;

  // one index counter serves both walks, so it must cover the wider one
  localparam int IDX_W = ((NB_MEM_ADDR - 2) > NB_ADDR) ? (NB_MEM_ADDR - 2) : NB_ADDR;
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(N_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(N_MEM_WORDS - 1);

  function automatic logic [NB_MEM_ADDR-1:0] word_addr(input logic [IDX_W-1:0] idx);
    logic [IDX_W+1:0] full;
    full = {idx, 2'b00};
    return full[NB_MEM_ADDR-1:0];
  endfunction

  dump_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NB_ADDR-1:0]     reg_addr_q, reg_addr_d;
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic               xfer_s;
  logic               ser_load_s;
  logic               ser_advance_s;
  logic [NB_DATA-1:0] ser_word_s;
  logic [7:0]         ser_byte_s;
  logic [7:0]         ser_next_byte_s;
  logic               ser_last_s;

  assign xfer_s = tx_valid_q & tx.tx_ready;

  dump_word_serializer #(.NB_DATA(NB_DATA)) u_ser (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load      (ser_load_s),
    .i_word      (ser_word_s),
    .i_advance   (ser_advance_s),
    .o_byte      (ser_byte_s),
    .o_next_byte (ser_next_byte_s),
    .o_last      (ser_last_s)
  );

  // frame sequencing; output bytes are computed one cycle ahead so they leave from flops
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    reg_addr_d    = reg_addr_q;
    mem_addr_d    = mem_addr_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    ser_load_s    = 1'b0;
    ser_advance_s = 1'b0;
    ser_word_s    = {NB_DATA{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          ser_load_s = 1'b1;
          ser_word_s = i_pc;
          tx_data_d  = DUMP_HDR;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_HEADER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HEADER: begin
        if (xfer_s) begin
          tx_data_d = ser_byte_s;
          state_d   = ST_PC;
        end else begin
          state_d = ST_HEADER;
        end
      end

      ST_PC: begin
        if (xfer_s && ser_last_s) begin
          tx_valid_d = 1'b0;
          reg_addr_d = NB_ADDR'(idx_q);
          state_d    = ST_REG_REQ;
        end else if (xfer_s) begin
          ser_advance_s = 1'b1;
          tx_data_d     = ser_next_byte_s;
        end else begin
          state_d = ST_PC;
        end
      end

      ST_REG_REQ:   state_d = ST_REG_LATCH;

      ST_REG_LATCH: begin
        ser_load_s = 1'b1;
        ser_word_s = i_reg_data;
        tx_data_d  = msb_byte(i_reg_data);
        tx_valid_d = 1'b1;
        state_d    = ST_REG_SEND;
      end

      ST_REG_SEND: begin
        if (xfer_s && ser_last_s) begin
          tx_valid_d = 1'b0;
          if (idx_q == LAST_REG) begin
            idx_d      = {IDX_W{1'b0}};
            mem_addr_d = word_addr({IDX_W{1'b0}});
            state_d    = ST_MEM_REQ;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            reg_addr_d = NB_ADDR'(idx_q + IDX_W'(1));
            state_d    = ST_REG_REQ;
          end
        end else if (xfer_s) begin
          ser_advance_s = 1'b1;
          tx_data_d     = ser_next_byte_s;
        end else begin
          state_d = ST_REG_SEND;
        end
      end

      ST_MEM_REQ:   state_d = ST_MEM_LATCH;

      ST_MEM_LATCH: begin
        ser_load_s = 1'b1;
        ser_word_s = i_mem_data;
        tx_data_d  = msb_byte(i_mem_data);
        tx_valid_d = 1'b1;
        state_d    = ST_MEM_SEND;
      end

      ST_MEM_SEND: begin
        if (xfer_s && ser_last_s) begin
          if (idx_q == LAST_MEM) begin
            idx_d      = {IDX_W{1'b0}};
            tx_data_d  = DUMP_TRL;
            tx_valid_d = 1'b1;
            state_d    = ST_TRAILER;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            mem_addr_d = word_addr(idx_q + IDX_W'(1));
            tx_valid_d = 1'b0;
            state_d    = ST_MEM_REQ;
          end
        end else if (xfer_s) begin
          ser_advance_s = 1'b1;
          tx_data_d     = ser_next_byte_s;
        end else begin
          state_d = ST_MEM_SEND;
        end
      end

      ST_TRAILER: begin
        if (xfer_s) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_TRAILER;
        end
      end

      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      reg_addr_q <= {NB_ADDR{1'b0}};
      mem_addr_q <= {NB_MEM_ADDR{1'b0}};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_reg_addr  = reg_addr_q;
  assign o_mem_addr  = mem_addr_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_pipeline_dump_unit.sv
// Directed bench for pipeline_dump_unit: register/memory read models, a
// byte-stream monitor and one task per scenario.
module tb_pipeline_dump_unit;

  localparam int FRAME_LEN = 390;
  localparam int TIMEOUT   = 3000;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  bit          rnd_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  pipeline_dump_unit_if tx_if ();

  pipeline_dump_unit dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_pc       (i_pc),
    .o_reg_addr (reg_addr),
    .i_reg_data (reg_data),
    .o_mem_addr (mem_addr),
    .i_mem_data (mem_data),
    .tx         (tx_if),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  // synchronous-read register file and data memory contents
  always @(posedge clk) begin
    reg_data <= 32'h1000_0000 + {27'd0, reg_addr};
    mem_data <= 32'hCAFE_0000 + {26'd0, mem_addr[7:2]};
  end

  always @(posedge clk) begin
    #1;
    tx_if.tx_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  logic [7:0] rx_q[$];
  logic [4:0] reg_log[$];
  logic [7:0] mem_log[$];
  int         stall_viol = 0;
  int         done_cnt   = 0;
  int         done_viol  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_done  = 1'b0;
  logic       prev_busy  = 1'b0;
  logic [4:0] last_reg   = 5'd0;
  logic [7:0] last_mem   = 8'd0;

  // stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) rx_q.push_back(tx_if.tx_data);
    if (prev_stall && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data))
      stall_viol <= stall_viol + 1;
    prev_stall <= (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready === 1'b0);
    prev_data  <= tx_if.tx_data;
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (busy !== 1'b0 || !prev_busy || prev_done) done_viol <= done_viol + 1;
    end
    prev_done <= (done === 1'b1);
    prev_busy <= (busy === 1'b1);
    if (reg_addr != last_reg) reg_log.push_back(reg_addr);
    if (mem_addr != last_mem) mem_log.push_back(mem_addr);
    last_reg <= reg_addr;
    last_mem <= mem_addr;
  end

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc);
    logic [31:0] w;
    int k;
    if (i == 0) return 8'hA5;
    if (i == FRAME_LEN - 1) return 8'h5A;
    if (i < 5) begin
      w = pc;
      k = i - 1;
    end else begin
      k = (i - 5) % 4;
      if ((i - 5) / 4 < 32) w = 32'h1000_0000 + 32'((i - 5) / 4);
      else                  w = 32'hCAFE_0000 + 32'((i - 5) / 4 - 32);
    end
    return 8'(w >> (8 * (3 - k)));
  endfunction

  function automatic int count_bad(input int base, input logic [31:0] pc, output int first);
    int bad = 0;
    first = -1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (base + i >= rx_q.size() || rx_q[base + i] !== exp_byte(i, pc)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic start_frame(input logic [31:0] pc, output int base);
    base    = rx_q.size();
    i_pc    = pc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_pc = 32'h0;
    tick(); tick();
    i_rst = 1'b0;
    tick();
    checks++; if (reg_addr !== 5'd0)     begin errors++; $display("FAIL rst_reg_addr got %0h want 0", reg_addr); end
    checks++; if (mem_addr !== 8'd0)     begin errors++; $display("FAIL rst_mem_addr got %0h want 0", mem_addr); end
    checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %0h want 0", tx_if.tx_data); end
    checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_if.tx_valid); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b want 0", done); end
  endtask

  task automatic test_full_frame();
    int base, cycles, bad, first, dv0;
    dv0 = done_viol;
    start_frame(32'h0000_0040, base);
    checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hA5)
      begin errors++; $display("FAIL first_byte got v=%b d=%0h want v=1 d=a5", tx_if.tx_valid, tx_if.tx_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    wait_done(cycles);
    checks++; if (cycles !== 582) begin errors++; $display("FAIL frame_cycles got %0d want 582", cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", busy); end
    checks++; if (rx_q.size() - base !== FRAME_LEN)
      begin errors++; $display("FAIL frame_len got %0d want %0d", rx_q.size() - base, FRAME_LEN); end
    bad = count_bad(base, 32'h0000_0040, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_content got %0d bad bytes (first %0d) want 0", bad, first); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", done); end
    checks++; if (done_viol !== dv0) begin errors++; $display("FAIL done_busy_align got %0d want %0d", done_viol, dv0); end
  endtask

  task automatic test_addr_sequence();
    int base, cycles, rb, mb, bad;
    do_reset();
    rb = reg_log.size();
    mb = mem_log.size();
    start_frame(32'h0000_0040, base);
    wait_done(cycles);
    checks++; if (cycles >= TIMEOUT) begin errors++; $display("FAIL addr_seq_timeout got %0d want <%0d", cycles, TIMEOUT); end
    bad = 0;
    for (int k = 1; k < 32; k++) if (rb + k - 1 >= reg_log.size() || reg_log[rb + k - 1] !== 5'(k)) bad++;
    checks++; if (bad !== 0 || reg_log.size() - rb !== 31)
      begin errors++; $display("FAIL reg_addr_seq got %0d changes %0d bad want 31 changes 0 bad", reg_log.size() - rb, bad); end
    bad = 0;
    for (int j = 1; j < 64; j++) if (mb + j - 1 >= mem_log.size() || mem_log[mb + j - 1] !== 8'(4 * j)) bad++;
    checks++; if (bad !== 0 || mem_log.size() - mb !== 63)
      begin errors++; $display("FAIL mem_addr_seq got %0d changes %0d bad want 63 changes 0 bad", mem_log.size() - mb, bad); end
    checks++; if (reg_addr !== 5'd31)  begin errors++; $display("FAIL reg_addr_hold got %0d want 31", reg_addr); end
    checks++; if (mem_addr !== 8'hFC)  begin errors++; $display("FAIL mem_addr_hold got %0h want fc", mem_addr); end
  endtask

  task automatic test_backpressure();
    int base, cycles, bad, first, sv0;
    sv0 = stall_viol;
    rnd_ready = 1'b1;
    start_frame(32'h0000_0040, base);
    wait_done(cycles);
    rnd_ready = 1'b0;
    checks++; if (cycles >= TIMEOUT) begin errors++; $display("FAIL bp_timeout got %0d want <%0d", cycles, TIMEOUT); end
    checks++; if (rx_q.size() - base !== FRAME_LEN)
      begin errors++; $display("FAIL bp_len got %0d want %0d", rx_q.size() - base, FRAME_LEN); end
    bad = count_bad(base, 32'h0000_0040, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_content got %0d bad bytes (first %0d) want 0", bad, first); end
    checks++; if (stall_viol !== sv0) begin errors++; $display("FAIL bp_hold_stable got %0d want %0d", stall_viol, sv0); end
  endtask

  task automatic test_restart_ignored();
    int base, cycles, bad, first, dc0, n;
    tick();
    dc0 = done_cnt;
    start_frame(32'h0000_0040, base);
    cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      n = rx_q.size() - base;
      i_start = (n == 10 || n == 200 || n == 389);
      if (i_start) i_pc = 32'h1234_5678;
      tick();
      cycles++;
    end
    i_start = 1'b0;
    checks++; if (cycles >= TIMEOUT) begin errors++; $display("FAIL restart_timeout got %0d want <%0d", cycles, TIMEOUT); end
    for (int k = 0; k < 20; k++) tick();
    checks++; if (rx_q.size() - base !== FRAME_LEN)
      begin errors++; $display("FAIL restart_len got %0d want %0d", rx_q.size() - base, FRAME_LEN); end
    bad = count_bad(base, 32'h0000_0040, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL restart_content got %0d bad bytes (first %0d) want 0", bad, first); end
    checks++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0)
      begin errors++; $display("FAIL restart_idle got busy=%b valid=%b want 0 0", busy, tx_if.tx_valid); end
    checks++; if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", done_cnt - dc0); end
  endtask

  task automatic test_reset_abort();
    int base, cycles, bad, first, dc0, sz;
    dc0 = done_cnt;
    start_frame(32'h0000_0040, base);
    cycles = 0;
    while (rx_q.size() - base < 150 && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL abort_outputs got v=%b busy=%b done=%b want 0 0 0", tx_if.tx_valid, busy, done); end
    checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL abort_tx_data got %0h want 0", tx_if.tx_data); end
    sz = rx_q.size();
    for (int k = 0; k < 20; k++) tick();
    checks++; if (rx_q.size() !== sz) begin errors++; $display("FAIL abort_no_trailer got %0d extra bytes want 0", rx_q.size() - sz); end
    checks++; if (done_cnt !== dc0) begin errors++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, dc0); end
    start_frame(32'h0000_0040, base);
    wait_done(cycles);
    checks++; if (cycles !== 582) begin errors++; $display("FAIL abort_refill_cycles got %0d want 582", cycles); end
    bad = count_bad(base, 32'h0000_0040, first);
    checks++; if (bad !== 0 || rx_q.size() - base !== FRAME_LEN)
      begin errors++; $display("FAIL abort_refill_frame got %0d bad, len %0d want 0 bad, len %0d", bad, rx_q.size() - base, FRAME_LEN); end
  endtask

  task automatic test_pc_change();
    int base, cycles, bad, first;
    logic [31:0] pc_seen;
    tick();
    start_frame(32'h0000_0040, base);
    i_pc = 32'hFFFF_FFFF;
    wait_done(cycles);
    checks++; if (cycles >= TIMEOUT) begin errors++; $display("FAIL pc_timeout got %0d want <%0d", cycles, TIMEOUT); end
    pc_seen = {rx_q[base + 1], rx_q[base + 2], rx_q[base + 3], rx_q[base + 4]};
    checks++; if (pc_seen !== 32'h0000_0040) begin errors++; $display("FAIL pc_snapshot got %08h want 00000040", pc_seen); end
    bad = count_bad(base, 32'h0000_0040, first);
    checks++; if (bad !== 0) begin errors++; $display("FAIL pc_frame got %0d bad bytes (first %0d) want 0", bad, first); end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_pc    = 32'h0;
    test_reset();
    test_full_frame();
    test_addr_sequence();
    test_backpressure();
    test_restart_ignored();
    test_reset_abort();
    test_pc_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_dump_unit.md
Name: pipeline_dump_unit

Overview:
Debug readout engine for the MIPS pipeline. On a start pulse, normally issued when the pipeline halts, it snapshots the PC. It then walks the register file and the first N_MEM_WORDS of data memory through their read ports, and serialises everything as a framed byte stream over a valid/ready interface toward the UART TX. It is the read-side counterpart of the instruction-load path that writes program words into IF memory.

Parameters:
NB_DATA, 32, register/memory word width (fixed at 32 for byte serialisation)
NB_ADDR, 5, register-file address width (32 registers)
NB_MEM_ADDR, 8, data-memory byte address width
N_MEM_WORDS, 64, data-memory words dumped; N_MEM_WORDS*4 <= 2**NB_MEM_ADDR

Ports:
clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  single-cycle request to begin a dump
i_pc  in  NB_DATA  current PC, sampled on accepted start
o_reg_addr  out  NB_ADDR  register-file read address
i_reg_data  in  NB_DATA  register read data, valid 1 cycle after o_reg_addr
o_mem_addr  out  NB_MEM_ADDR  data-memory byte address (word index * 4)
i_mem_data  in  NB_DATA  memory read data, valid 1 cycle after o_mem_addr
o_tx_data  out  8  stream byte
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  consumer accepts byte when high with o_tx_valid
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse after the trailer byte transfers

Behaviour:
- Reset values: o_reg_addr=0, o_mem_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0; FSM in IDLE.
- Frame format, MSB-first per word: 0xA5, PC[4 bytes], R0..R31 [4 bytes each], MEM word 0..N_MEM_WORDS-1 [4 bytes each], 0x5A. Total = 134 + 4*N_MEM_WORDS bytes (390 at default).
- Handshake: a byte transfers on the cycle o_tx_valid && i_tx_ready. While o_tx_valid=1 and i_tx_ready=0, o_tx_data is held stable and o_tx_valid stays high. The unit presents at most one byte per cycle, and back-to-back transfers are allowed when ready stays high.
- FSM states:
  - IDLE: i_start=1 latches i_pc, sets o_busy, and moves to HEADER.
  - HEADER: presents 0xA5; on transfer moves to PC.
  - PC: presents 4 bytes; after the 4th transfer moves to REG_REQ.
  - REG_REQ: drives o_reg_addr=idx with o_tx_valid=0 for one cycle, then moves to REG_LATCH.
  - REG_LATCH: captures i_reg_data into the shift register and moves to REG_SEND.
  - REG_SEND: presents 4 bytes. After the 4th transfer it increments idx and returns to REG_REQ; if idx was 31 it clears idx and moves to MEM_REQ.
  - MEM_REQ, MEM_LATCH, MEM_SEND: same pattern with o_mem_addr = idx<<2; the last word moves to TRAILER.
  - TRAILER: presents 0x5A; on transfer it pulses o_done and returns to IDLE with o_busy=0.
- Latency: with i_tx_ready tied high, the first byte is valid the cycle after start. Each register/memory word costs 2 bubble cycles + 4 transfer cycles.
- i_start while o_busy=1 is ignored; the frame is unaffected.
- i_start in the same cycle as the trailer transfer is ignored; it must be re-issued after o_done.
- i_rst mid-frame aborts immediately, with all outputs at reset values the next cycle. No partial trailer is sent.
- i_pc changes after start have no effect on the frame.
- The unit never writes the register file or memory, and o_reg_addr/o_mem_addr hold their last value when not being used.

Decomposition:
- Shared package dump_pkg: state enum encoding, DUMP_HDR=8'hA5, DUMP_TRL=8'h5A, N_REGS=32, BYTES_PER_WORD=4.
- One natural sub-module, dump_word_serializer: loads a 32-bit word and emits 4 MSB-first bytes under valid/ready, with a last-byte flag. It is used for PC, register and memory words.

Test Plan:
- Regs Rk=0x1000_0000+k, mem word j=0xCAFE_0000+j, i_pc=0x0000_0040, ready tied high, start pulse -> 390 bytes: A5, 00 00 00 40, 10 00 00 00 ... 10 00 00 1F, CA FE 00 00 ... CA FE 00 3F, 5A; o_done is high one cycle, and o_busy falls the same cycle as o_done.
- i_tx_ready toggled pseudo-randomly (~30% low) -> byte stream identical to the previous case; o_tx_data stable whenever valid is high and ready is low; no byte dropped or duplicated.
- o_mem_addr monitor during a full dump -> exact sequence 0x00, 0x04, ..., 0xFC; o_reg_addr sequence 0..31.
- Second i_start pulses at byte 10 and byte 200 of an active frame -> frame length stays 390; no new frame starts after o_done.
- i_rst asserted at byte 150 for 1 cycle -> o_tx_valid=0 and o_busy=0 on the next cycle; a fresh start then produces a complete correct 390-byte frame.
- i_pc changed to 0xFFFF_FFFF one cycle after start -> PC bytes still 00 00 00 40.
